// File: rtl/shift_ctrl_pkg.sv
// Shared state encoding and sizing helper for the framed shift controller.
// The optional SHIFT_PARITY_EN build is handled in shift_frame_ctrl.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/shift_core.sv
// WIDTH-bit shift register with parallel load, MSB-first shift and parallel
// readout; the serial output is the MSB of dout.
module shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] shreg_r;

    // Shift register: load has priority over shift.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shreg_r <= {WIDTH{1'b0}};
        end else if (load) begin
            shreg_r <= din;
        end else if (shift) begin
            shreg_r <= {shreg_r[WIDTH-2:0], sin};
        end
    end

    assign dout = shreg_r;

endmodule

// File: rtl/shift_frame_ctrl.sv
// Framed serial transfer sequencer: FSM, counters, handshake and capture.
// Define SHIFT_PARITY_EN to append an even-parity bit to every frame.
module shift_frame_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             sin,
    output logic             sout,
    output logic             frame,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_perr
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES);
`ifdef SHIFT_PARITY_EN
    localparam logic [BW-1:0] LAST = BW'(WIDTH);
`else
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 32'sd1);
`endif
    localparam logic [BW-1:0] BIT_ONE  = BW'(32'sd1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(32'sd1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 32'sd1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [BW-1:0]    bitcnt_r;
    logic [GW-1:0]    gapcnt_r;
    logic             load_s;
    logic             shift_s;
    logic             done_s;
    logic             gap_done_s;
    logic [WIDTH-1:0] core_dout_s;
    logic [WIDTH-1:0] capture_s;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid_r;

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .clr   (clr),
        .load  (load_s),
        .shift (shift_s),
        .din   (tx_data),
        .sin   (sin),
        .dout  (core_dout_s)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        done_s      = 1'b0;
        gap_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
`ifdef SHIFT_PARITY_EN
                // The parity cycle samples sin without disturbing the word.
                shift_s = (bitcnt_r != LAST);
`else
                shift_s = 1'b1;
`endif
                if (bitcnt_r == LAST) begin
                    done_s = 1'b1;
                    if (GAP_CYCLES > 32'sd0) begin
                        state_nxt_s = ST_GAP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (gapcnt_r == GAP_LAST) begin
                    gap_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit and gap counters; neither wraps.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bitcnt_r <= {BW{1'b0}};
            gapcnt_r <= {GW{1'b0}};
        end else begin
            if (load_s) begin
                bitcnt_r <= {BW{1'b0}};
            end else if ((state_r == ST_SHIFT) && !done_s) begin
                bitcnt_r <= bitcnt_r + BIT_ONE;
            end
            if (state_r == ST_GAP) begin
                gapcnt_r <= gap_done_s ? {GW{1'b0}} : (gapcnt_r + GAP_ONE);
            end
        end
    end

`ifdef SHIFT_PARITY_EN
    logic par_r;
    logic rx_perr_r;

    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Parity of the word being transmitted, captured at load.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_r <= 1'b0;
        end else if (load_s) begin
            par_r <= even_par(tx_data);
        end
    end

    assign capture_s = core_dout_s;

    // Parity error flag, updated alongside rx_data.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_perr_r <= 1'b0;
        end else if (done_s) begin
            rx_perr_r <= sin ^ even_par(core_dout_s);
        end
    end

    assign rx_perr = rx_perr_r;

    // Serial output: data MSB, then the parity bit in the last frame cycle.
    always_comb begin
        if (state_r == ST_SHIFT) begin
            if (bitcnt_r == LAST) begin
                sout = par_r;
            end else begin
                sout = core_dout_s[WIDTH-1];
            end
        end else begin
            sout = 1'b0;
        end
    end
`else
    // The final sin bit lands in the word on the same edge it is captured.
    assign capture_s = {core_dout_s[WIDTH-2:0], sin};
    assign rx_perr   = 1'b0;

    // Serial output: register MSB while shifting, low otherwise.
    always_comb begin
        if (state_r == ST_SHIFT) begin
            sout = core_dout_s[WIDTH-1];
        end else begin
            sout = 1'b0;
        end
    end
`endif

    // Received word and its one-cycle valid pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_data_r  <= {WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= done_s;
            if (done_s) begin
                rx_data_r <= capture_s;
            end
        end
    end

    assign tx_ready = (state_r == ST_IDLE);
    assign frame    = (state_r == ST_SHIFT);
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Randomised self-checking bench for shift_frame_ctrl (WIDTH=4, GAP_CYCLES=1);
// build with SHIFT_PARITY_EN defined to exercise the parity bit.
module tb_shift_frame_ctrl;

    localparam int WIDTH = 4;
    localparam int GAP   = 1;
`ifdef SHIFT_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int PERIOD = FLEN + 1 + GAP;

    logic             clk = 1'b0;
    logic             clr;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             sin_s;
    logic             sin_drv;
    logic             loop_en;
    logic             sout;
    logic             frame;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_perr;

    int checks = 0;
    int errors = 0;

    assign sin_s = loop_en ? sout : sin_drv;

    always #5 clk = ~clk;

    shift_frame_ctrl #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sin      (sin_s),
        .sout     (sout),
        .frame    (frame),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_perr  (rx_perr)
    );

    // One complete frame; sin_bits[FLEN-1] is the first bit driven on sin.
    task automatic do_frame(input string name, input logic [WIDTH-1:0] word,
                            input logic use_loop, input logic [FLEN-1:0] sin_bits);
        logic             exp_bit [FLEN];
        logic             rcv_bit [FLEN];
        logic [WIDTH-1:0] exp_rx;
        logic             exp_perr;
        for (int i = 0; i < WIDTH; i++) exp_bit[i] = word[WIDTH-1-i];
        if (FLEN > WIDTH) exp_bit[FLEN-1] = ^word;
        for (int i = 0; i < FLEN; i++) rcv_bit[i] = use_loop ? exp_bit[i] : sin_bits[FLEN-1-i];
        for (int i = 0; i < WIDTH; i++) exp_rx[WIDTH-1-i] = rcv_bit[i];
        exp_perr = (FLEN > WIDTH) ? (rcv_bit[FLEN-1] ^ (^exp_rx)) : 1'b0;

        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL %s tx_ready before load: got %b want 1", name, tx_ready);
        end
        loop_en  = use_loop;
        tx_data  = word;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = WIDTH'($urandom);
        for (int i = 0; i < FLEN; i++) begin
            sin_drv = sin_bits[FLEN-1-i];
            checks++;
            if (frame !== 1'b1 || sout !== exp_bit[i] || tx_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s bit %0d: frame=%b sout=%b tx_ready=%b want frame=1 sout=%b tx_ready=0",
                         name, i, frame, sout, tx_ready, exp_bit[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (frame !== 1'b0 || sout !== 1'b0 || rx_valid !== 1'b1 || rx_data !== exp_rx || rx_perr !== exp_perr) begin
            errors++;
            $display("FAIL %s capture: frame=%b sout=%b rx_valid=%b rx_data=%h rx_perr=%b want 0 0 1 %h %b",
                     name, frame, sout, rx_valid, rx_data, rx_perr, exp_rx, exp_perr);
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== exp_rx || rx_perr !== exp_perr) begin
            errors++;
            $display("FAIL %s hold: rx_valid=%b rx_data=%h rx_perr=%b want 0 %h %b",
                     name, rx_valid, rx_data, rx_perr, exp_rx, exp_perr);
        end
        repeat (GAP) @(negedge clk);
        loop_en = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1 || frame !== 1'b0 || sout !== 1'b0 || rx_valid !== 1'b0 ||
            rx_data !== 4'h0 || rx_perr !== 1'b0) begin
            errors++;
            $display("FAIL reset: tx_ready=%b frame=%b sout=%b rx_valid=%b rx_data=%h rx_perr=%b want 1 0 0 0 0 0",
                     tx_ready, frame, sout, rx_valid, rx_data, rx_perr);
        end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || frame !== 1'b0) begin
            errors++; $display("FAIL reset_release: tx_ready=%b frame=%b want 1 0", tx_ready, frame);
        end
    endtask

    task automatic test_single();
        do_frame("single_1011", 4'b1011, 1'b1, {FLEN{1'b0}});
    endtask

    task automatic test_indep_sin();
        logic [FLEN-1:0] sb;
        sb = {FLEN{1'b0}};
        sb[FLEN-1 -: WIDTH] = 4'b0110;
        do_frame("indep_sin", 4'hF, 1'b0, sb);
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 16; n++) begin
            do_frame("random", WIDTH'($urandom), 1'($urandom_range(0, 1)), FLEN'($urandom));
        end
    endtask

    // tx_valid held throughout with changing data; loads only happen in IDLE.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] acc [3];
        int nc;
        nc = 3 * PERIOD + FLEN + 2;
        loop_en = 1'b1;
        @(negedge clk);
        for (int c = 0; c < nc; c++) begin
            int  p;
            int  cr;
            int  fi;
            logic exp_ready;
            logic exp_frame;
            logic exp_rxv;
            logic exp_sout;
            p         = c % PERIOD;
            fi        = c / PERIOD;
            cr        = c - (FLEN + 1);
            exp_ready = (c >= 3 * PERIOD) || (p == 0);
            exp_frame = (c < 3 * PERIOD) && (p >= 1) && (p <= FLEN);
            exp_rxv   = (cr >= 0) && (cr % PERIOD == 0) && (cr / PERIOD < 3);
            exp_sout  = 1'b0;
            if (exp_frame) exp_sout = (p <= WIDTH) ? acc[fi][WIDTH-p] : ^acc[fi];
            checks++;
            if (tx_ready !== exp_ready || frame !== exp_frame || sout !== exp_sout || rx_valid !== exp_rxv) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: tx_ready=%b frame=%b sout=%b rx_valid=%b want %b %b %b %b",
                         c, tx_ready, frame, sout, rx_valid, exp_ready, exp_frame, exp_sout, exp_rxv);
            end
            if (exp_rxv) begin
                checks++;
                if (rx_data !== acc[cr / PERIOD] || rx_perr !== 1'b0) begin
                    errors++;
                    $display("FAIL back_to_back data %0d: rx_data=%h rx_perr=%b want %h 0",
                             cr / PERIOD, rx_data, rx_perr, acc[cr / PERIOD]);
                end
            end
            if (c < 3 * PERIOD) begin
                tx_valid = 1'b1;
                tx_data  = WIDTH'($urandom);
                if (p == 0) acc[fi] = tx_data;
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_abort();
        do_frame("pre_abort", 4'hA, 1'b1, {FLEN{1'b0}});
        @(negedge clk);
        tx_data  = 4'h5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (frame !== 1'b1) begin
            errors++; $display("FAIL abort_pre: frame=%b want 1", frame);
        end
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if (frame !== 1'b0 || sout !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 4'h0) begin
            errors++;
            $display("FAIL abort_clr: frame=%b sout=%b tx_ready=%b rx_valid=%b rx_data=%h want 0 0 1 0 0",
                     frame, sout, tx_ready, rx_valid, rx_data);
        end
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < FLEN + 2; i++) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0 || frame !== 1'b0) begin
                errors++; $display("FAIL abort_quiet %0d: rx_valid=%b frame=%b want 0 0", i, rx_valid, frame);
            end
        end
        do_frame("abort_recover", 4'h6, 1'b1, {FLEN{1'b0}});
    endtask

`ifdef SHIFT_PARITY_EN
    task automatic test_parity();
        do_frame("parity_good", 4'b0111, 1'b1, {FLEN{1'b0}});
        do_frame("parity_bad", 4'b0111, 1'b0, {4'b0111, 1'b0});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr      = 1'b1;
        tx_data  = {WIDTH{1'b0}};
        tx_valid = 1'b0;
        sin_drv  = 1'b0;
        loop_en  = 1'b1;
        test_reset();
        test_single();
        test_indep_sin();
        test_random_frames();
        test_back_to_back();
        test_abort();
`ifdef SHIFT_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
